// File: rtl/divider_pkg.sv
// Shared definitions for the divider/multiplier pair: FSM encoding,
// default operand widths and a constant-width helper.
package divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_WIDTH_A = 8;
  localparam int DEF_WIDTH_B = 4;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/general_multiplier.sv
// Iterative shift-and-add recombiner: P = Q*B + R, one multiplier bit per clock.
// Inverse of general_divider; the accumulator is exposed on pa for debug.
module general_multiplier
  import divider_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH_A-1:0]         Q,
  input  logic [WIDTH_B-1:0]         B,
  input  logic [WIDTH_B-1:0]         R,
  output logic [WIDTH_A+WIDTH_B-1:0] P,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf,
  output logic                       rem_ok,
  output logic [WIDTH_A+WIDTH_B-1:0] pa
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int CW = clog2(WIDTH_A + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH_A - 1);

  logic [1:0]         r_state;
  logic [WIDTH_A-1:0] r_mq;
  logic [WIDTH_B-1:0] r_mb;
  logic [PW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_p;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic               r_rem_ok;

  logic [PW-1:0]      w_mb_ext;
  logic [PW-1:0]      w_addend;
  logic               w_ovf;
  logic               w_rem_ok;

  // The sum never exceeds PW bits, so no carry-out is kept.
  assign w_mb_ext = {{WIDTH_A{1'b0}}, r_mb};
  assign w_addend = w_mb_ext << r_cnt;
  assign w_ovf    = |r_acc[PW-1:WIDTH_A];
  assign w_rem_ok = (B != '0) && (R < B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_mq     <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_rem_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mq     <= Q;
            r_mb     <= B;
            r_acc    <= {{WIDTH_A{1'b0}}, R};
            r_cnt    <= '0;
            r_rem_ok <= w_rem_ok;
            r_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (r_mq[0]) r_acc <= r_acc + w_addend;
          r_mq  <= r_mq >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_p     <= r_acc;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign P      = r_p;
  assign busy   = r_busy;
  assign done   = r_done;
  assign ovf    = r_ovf;
  assign rem_ok = r_rem_ok;
  assign pa     = r_acc;

endmodule
